maxpool_stream: RTL and testbench
=================================

Name: maxpool_stream

Overview:
Parametrised streaming max-pooling stage for the 1-D CNN datapath. It replaces the fixed combinational 5-input, 8-channel pooling layers. Per-channel samples arrive one time-step per handshake, and the block emits one max per channel for every non-overlapping window of POOL_SIZE samples. It sits between a conv/activation stage and the next conv or dense stage, with valid/ready on both sides and frame delimiting.

Parameters:
- NUM_CH, 8: number of parallel channels.
- DATA_W, 8: sample width in bits.
- POOL_SIZE, 5: window length = stride (non-overlapping); legal range 1..64.
- SIGNED, 1: 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  global enable; low freezes all state.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  [NUM_CH-1:0][DATA_W-1:0]  one sample per channel.
- in_last  input  1  sample is the final one of the frame.
- out_valid  output  1  pooled result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  [NUM_CH-1:0][DATA_W-1:0]  window max per channel.
- out_last  output  1  result is the final window of the frame.
- out_idx  output  [NUM_CH-1:0][$clog2(POOL_SIZE)-1:0]  argmax position; present only with the optional feature.

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid=0, out_last=0, out_data=0, out_idx=0.
  - Window counter=0, accumulators=0.
  - Any partial window is discarded.
- Ready and accept:
  - in_ready = en & (!out_valid | out_ready).
  - Accept = in_valid & in_ready. Output fire = out_valid & out_ready & en.
- en low: no accept, no fire, all registers hold.
- Counter cnt runs 0..POOL_SIZE-1.
  - cnt==0 on accept: acc <= in_data (load).
  - Otherwise: acc <= max(acc, in_data) per channel.
- Window completion: an accept with cnt==POOL_SIZE-1 or in_last=1.
  - out_data <= max(acc, in_data); when cnt==0, out_data <= in_data.
  - out_valid <= 1, out_last <= in_last, cnt <= 0.
- Non-completing accept: cnt <= cnt+1; out_valid is unaffected.
- Latency: the result is visible one cycle after the completing accept.
- Throughput: 1 sample/cycle while out_ready=1.
- Output hold: while out_valid & !out_ready, out_data, out_last and out_idx are held stable.
- Same-cycle fire and completing accept: the new result loads and out_valid stays 1.
- Fire without a new completion: out_valid <= 0.
- Partial window: in_last with cnt<POOL_SIZE-1 emits the max of the samples received so far (ceil mode).
- POOL_SIZE=1: registered pass-through; every accept completes a window.
- Compare rule:
  - SIGNED=1: $signed compare. SIGNED=0: unsigned compare.
  - Ties keep the earlier value.
  - No width growth; out width = DATA_W.

Optional Feature:
- MAXPOOL_ARGMAX_EN defined:
  - Adds out_idx: per channel, the position 0..POOL_SIZE-1 within the window of the first occurrence of the max.
  - out_idx follows the same load and hold rules as out_data.
- Not defined: the out_idx port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package maxpool_pkg holds:
  - Default constants: NUM_CH_DEF, DATA_W_DEF, POOL_SIZE_DEF.
  - Function max_sel(a, b, is_signed) returning the larger value, earlier value on ties.
  - typedef idx_t sized for POOL_SIZE_DEF.
- Sub-module maxpool_channel: one per channel, generated NUM_CH times.
  - Holds the accumulator, the argmax register and the compare logic.
  - The top holds the counter, handshake and frame logic.

Test Plan:
1. Default params, out_ready=1, channel 0 fed 3,9,2,7,1 (last on the 5th) -> one result of 9, out_last=1, 1 cycle after the 5th accept; out_idx=1 with ARGMAX.
2. SIGNED=1, channel fed -5,-2,-8,-1,-3 (8'hFB,FE,F8,FF,FD) -> 8'hFF. Same bytes with SIGNED=0 -> 8'hFF; 8'h7F vs 8'h80 gives 8'h80 unsigned and 8'h7F signed.
3. Frame of 7 samples 1..7 with last on the 7th -> outputs 5 (out_last=0) then 7 (out_last=1, partial window).
4. out_ready=0 for 10 cycles after the first result -> in_ready drops; out_data is held; nothing is lost; results are in order after release.
5. Assert rst low mid-window after 3 samples, release, feed 5 samples of 4 -> single result 4; no stale max.
6. en low for 4 cycles mid-window with in_valid=1 -> no accepts, state frozen; resumes with the correct max.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared constants, types and the compare helper for the streaming max-pool block.
// Optional argmax output is enabled by defining MAXPOOL_ARGMAX_EN.
package maxpool_pkg;

    localparam int NUM_CH_DEF    = 8;
    localparam int DATA_W_DEF    = 8;
    localparam int POOL_SIZE_DEF = 5;

    // Widest sample the compare helper handles; callers extend into this width.
    localparam int CMP_W = 64;

    localparam int IDX_W_DEF = (POOL_SIZE_DEF > 1) ? $clog2(POOL_SIZE_DEF) : 1;
    typedef logic [IDX_W_DEF-1:0] idx_t;

    // Larger of a and b; a (the earlier value) wins ties.
    // Callers sign-extend for signed compares and zero-extend otherwise.
    function automatic logic [CMP_W-1:0] max_sel(input logic [CMP_W-1:0] a,
                                                 input logic [CMP_W-1:0] b,
                                                 input logic             is_signed);
        logic b_gt;
        if (is_signed)
            b_gt = $signed(b) > $signed(a);
        else
            b_gt = b > a;
        return b_gt ? b : a;
    endfunction

endpackage

// File: rtl/maxpool_channel.sv
// Per-channel accumulator and compare path for maxpool_stream.
// With MAXPOOL_ARGMAX_EN defined, also tracks the position of the first maximum.
module maxpool_channel
    import maxpool_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int POOL_SIZE = POOL_SIZE_DEF,
    parameter int SIGNED    = 1,
    parameter int IDX_W     = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              complete,
    input  logic              first,
    input  logic [DATA_W-1:0] sample,
`ifdef MAXPOOL_ARGMAX_EN
    input  logic [IDX_W-1:0]  pos,
    output logic [IDX_W-1:0]  res_idx,
`endif
    output logic [DATA_W-1:0] res
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] cand;
    logic [CMP_W-1:0]  a_ext;
    logic [CMP_W-1:0]  b_ext;
    logic [CMP_W-1:0]  m_ext;
    logic              b_wins;

`ifdef MAXPOOL_ARGMAX_EN
    logic [IDX_W-1:0]  acc_idx_q;
    logic [IDX_W-1:0]  cand_idx;
`endif

    // Candidate value: the new sample opens a window, otherwise running max with it.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = CMP_W'($signed(acc_q));
            b_ext = CMP_W'($signed(sample));
        end else begin
            a_ext = CMP_W'(acc_q);
            b_ext = CMP_W'(sample);
        end
        m_ext  = max_sel(a_ext, b_ext, SIGNED != 0);
        b_wins = first || (m_ext != a_ext);
        cand   = b_wins ? sample : acc_q;
`ifdef MAXPOOL_ARGMAX_EN
        cand_idx = first ? '0 : (b_wins ? pos : acc_idx_q);
`endif
    end

    // Accumulator tracks the running max; result register captures it on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            res   <= '0;
        end else begin
            if (accept)
                acc_q <= cand;
            if (complete)
                res <= cand;
        end
    end

`ifdef MAXPOOL_ARGMAX_EN
    // Argmax follows the same load/hold rules as the value path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_idx_q <= '0;
            res_idx   <= '0;
        end else begin
            if (accept)
                acc_idx_q <= cand_idx;
            if (complete)
                res_idx <= cand_idx;
        end
    end
`endif

endmodule

// File: rtl/maxpool_stream.sv
// Streaming non-overlapping max-pool over NUM_CH channels with valid/ready and framing.
// Define MAXPOOL_ARGMAX_EN to add the out_idx argmax port.
module maxpool_stream
    import maxpool_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int POOL_SIZE = POOL_SIZE_DEF,
    parameter int SIGNED    = 1,
    parameter int IDX_W     = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH-1:0][DATA_W-1:0] in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH-1:0][DATA_W-1:0] out_data,
`ifdef MAXPOOL_ARGMAX_EN
    output logic [NUM_CH-1:0][IDX_W-1:0]  out_idx,
`endif
    output logic                          out_last
);

    logic [IDX_W-1:0] cnt;
    logic             accept;
    logic             fire;
    logic             complete;
    logic             first;

    // Handshake: en gates both sides so a low enable freezes everything.
    always_comb begin
        in_ready = en & (~out_valid | out_ready);
        accept   = in_valid & in_ready;
        fire     = out_valid & out_ready & en;
        first    = (cnt == '0);
        complete = accept & (in_last | (cnt == IDX_W'(POOL_SIZE - 1)));
    end

    // Window position counter; in_last closes a short window early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (complete)
            cnt <= '0;
        else if (accept)
            cnt <= cnt + 1'b1;
    end

    // Output valid/last: a new completion overrides a same-cycle fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_last  <= in_last;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        maxpool_channel #(
            .DATA_W    (DATA_W),
            .POOL_SIZE (POOL_SIZE),
            .SIGNED    (SIGNED),
            .IDX_W     (IDX_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .accept   (accept),
            .complete (complete),
            .first    (first),
            .sample   (in_data[c]),
`ifdef MAXPOOL_ARGMAX_EN
            .pos      (cnt),
            .res_idx  (out_idx[c]),
`endif
            .res      (out_data[c])
        );
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: signed and unsigned instances share stimulus,
// checked every cycle against a window-list reference model.
module tb_maxpool_stream;

    localparam int NC = 8;
    localparam int DW = 8;
    localparam int PS = 5;
    localparam int IW = $clog2(PS);

    typedef logic [NC-1:0][DW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    vec_t in_data = '0;

    logic in_ready, out_valid, out_last;
    logic in_ready_u, out_valid_u, out_last_u;
    vec_t out_data, out_data_u;
`ifdef MAXPOOL_ARGMAX_EN
    logic [NC-1:0][IW-1:0] out_idx, out_idx_u;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    maxpool_stream #(.NUM_CH(NC), .DATA_W(DW), .POOL_SIZE(PS), .SIGNED(1)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MAXPOOL_ARGMAX_EN
        .out_idx(out_idx),
`endif
        .out_last(out_last)
    );

    maxpool_stream #(.NUM_CH(NC), .DATA_W(DW), .POOL_SIZE(PS), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
`ifdef MAXPOOL_ARGMAX_EN
        .out_idx(out_idx_u),
`endif
        .out_last(out_last_u)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: collect whole windows, then take per-channel max of the list.
    vec_t winq[$];
    logic mvalid = 1'b0;
    logic mlast  = 1'b0;
    vec_t ms = '0;
    vec_t mu = '0;
    logic [NC-1:0][IW-1:0] mis = '0;
    logic [NC-1:0][IW-1:0] miu = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            winq.delete();
            mvalid = 1'b0;
            mlast  = 1'b0;
            ms  = '0;
            mu  = '0;
            mis = '0;
            miu = '0;
        end else begin
            bit rdy, acc, fir;
            rdy = en && (!mvalid || out_ready);
            acc = in_valid && rdy;
            fir = mvalid && out_ready && en;
            if (fir)
                mvalid = 1'b0;
            if (acc) begin
                winq.push_back(in_data);
                if (winq.size() == PS || in_last) begin
                    for (int c = 0; c < NC; c++) begin
                        logic [DW-1:0] bs, bu;
                        int is, iu;
                        bs = winq[0][c]; bu = winq[0][c]; is = 0; iu = 0;
                        for (int k = 1; k < winq.size(); k++) begin
                            if ($signed(winq[k][c]) > $signed(bs)) begin bs = winq[k][c]; is = k; end
                            if (winq[k][c] > bu) begin bu = winq[k][c]; iu = k; end
                        end
                        ms[c] = bs; mu[c] = bu;
                        mis[c] = IW'(is); miu[c] = IW'(iu);
                    end
                    mvalid = 1'b1;
                    mlast  = in_last;
                    winq.delete();
                end
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        bit rdy;
        rdy = en && (!mvalid || out_ready);
        chk("in_ready", in_ready, rdy);
        chk("in_ready_u", in_ready_u, rdy);
        chk("out_valid", out_valid, mvalid);
        chk("out_valid_u", out_valid_u, mvalid);
        chk("out_data", out_data, ms);
        chk("out_data_u", out_data_u, mu);
        if (mvalid) begin
            chk("out_last", out_last, mlast);
            chk("out_last_u", out_last_u, mlast);
`ifdef MAXPOOL_ARGMAX_EN
            chk("out_idx", out_idx, mis);
            chk("out_idx_u", out_idx_u, miu);
`endif
        end
    end

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int c = 0; c < NC; c++)
            v[c] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
        return v;
    endfunction

    // Hold a sample on the input until the handshake completes (bounded).
    task automatic send(input vec_t d, input bit l);
        bit ok;
        in_valid = 1'b1;
        in_last  = l;
        in_data  = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ok = en && (!mvalid || out_ready);
            @(posedge clk);
            #1;
            if (ok) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        chk("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_ch0(input logic [DW-1:0] s0, input bit l);
        vec_t v;
        v = rnd_vec();
        v[0] = s0;
        send(v, l);
    endtask

    initial begin
        vec_t v;
        logic [DW-1:0] t1 [5];
        logic [DW-1:0] t2 [5];
        t1 = '{8'd3, 8'd9, 8'd2, 8'd7, 8'd1};
        t2 = '{8'hFB, 8'hFE, 8'hF8, 8'hFF, 8'hFD};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_data", out_data, '0);
        rst = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;

        // 1: basic window, max 9 at position 1
        for (int i = 0; i < 5; i++) send_ch0(t1[i], i == 4);
        chk("t1_max", out_data[0], 8'd9);
        chk("t1_last", out_last, 1'b1);
`ifdef MAXPOOL_ARGMAX_EN
        chk("t1_idx", out_idx[0], 3'd1);
`endif

        // 2: negative values; 7F vs 80 on channel 1
        for (int i = 0; i < 5; i++) begin
            v = rnd_vec();
            v[0] = t2[i];
            v[1] = (i == 0) ? 8'h7F : ((i == 1) ? 8'h80 : 8'h00);
            send(v, i == 4);
        end
        chk("t2_s_ch0", out_data[0], 8'hFF);
        chk("t2_u_ch0", out_data_u[0], 8'hFF);
        chk("t2_s_ch1", out_data[1], 8'h7F);
        chk("t2_u_ch1", out_data_u[1], 8'h80);

        // 3: 7-sample frame -> full window then partial window
        for (int i = 1; i <= 7; i++) begin
            send_ch0(DW'(i), i == 7);
            if (i == 5) begin
                chk("t3_w0", out_data[0], 8'd5);
                chk("t3_w0_last", out_last, 1'b0);
            end
        end
        chk("t3_w1", out_data[0], 8'd7);
        chk("t3_w1_last", out_last, 1'b1);

        // 4: backpressure for 10 cycles after a result
        for (int i = 0; i < 5; i++) send_ch0(DW'(10 + i), 1'b0);
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 5; i++) send_ch0(DW'(20 - i), i == 4);
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("t4_held", out_data[0], 8'd14);
                out_ready = 1'b1;
            end
        join
        chk("t4_second", out_data[0], 8'd20);

        // 5: reset mid-window discards the partial max
        for (int i = 0; i < 3; i++) send_ch0(8'd100, 1'b0);
        rst = 1'b0;
        #2;
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_data", out_data[0], 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) send_ch0(8'd4, i == 4);
        chk("t5_result", out_data[0], 8'd4);

        // 6: enable low mid-window with valid held
        send_ch0(8'd2, 1'b0);
        send_ch0(8'd6, 1'b0);
        in_valid = 1'b1;
        in_data = rnd_vec();
        in_data[0] = 8'd99;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        en = 1'b1;
        in_valid = 1'b0;
        send_ch0(8'd1, 1'b0);
        send_ch0(8'd3, 1'b0);
        send_ch0(8'd5, 1'b1);
        chk("t6_result", out_data[0], 8'd6);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 7) == 0);
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = rnd_vec();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
